multi_cycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the RV32I datapath (PC register, instruction latch, register file, ALU, ALU-source mux, data-memory port) for R-type, I-type ALU and S-type instructions.
- Captures decode fields once per instruction.
- Issues datapath enables phase by phase.
- Handshakes with data memory for stores.
- Traps on illegal opcodes or memory timeout.

---
 rtl/rv32i_ctrl_pkg.sv | 37 +++
 rtl/multi_cycle_ctrl_if.sv | 31 +++
 rtl/alu_op_decode.sv | 45 ++++
 rtl/multi_cycle_ctrl.sv | 133 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller:
// FSM states, instruction classes, opcodes and ALU operation codes.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    InstNone,
    InstR,
    InstI,
    InstS
  } inst_class_e;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;

  // ALU op encoding is {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller uses the master
// modport; the datapath side (or a testbench) uses the slave modport.
interface multi_cycle_ctrl_if;

  logic [31:0] iInst_Code;
  logic        iMem_Ready;
  logic        oIR_En;
  logic        oPC_En;
  logic [3:0]  oALU_Control;
  logic        oALUSrcMuxSel;
  logic        oWrEn;
  logic        oData_Req;
  logic        oData_WrEn;
  logic [2:0]  oState;
  logic        oIllegal;
  logic        oFault;
  logic [31:0] oRetired_Cnt;

  modport master (
    input  iInst_Code, iMem_Ready,
    output oIR_En, oPC_En, oALU_Control, oALUSrcMuxSel, oWrEn, oData_Req,
           oData_WrEn, oState, oIllegal, oFault, oRetired_Cnt
  );

  modport slave (
    output iInst_Code, iMem_Ready,
    input  oIR_En, oPC_En, oALU_Control, oALUSrcMuxSel, oWrEn, oData_Req,
           oData_WrEn, oState, oIllegal, oFault, oRetired_Cnt
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of latched {opcode, funct3, funct7[5]} into instruction
// class, ALU op, ALU source select and an illegal-encoding flag.
module alu_op_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  output inst_class_e o_class,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_illegal
);

  always_comb begin
    o_class   = InstNone;
    o_alu_op  = ALU_ADD;
    o_alu_src = 1'b0;
    o_illegal = 1'b1;
    case (i_opcode)
      OP_R_TYPE: begin
        o_class   = InstR;
        o_alu_op  = {i_funct7b5, i_funct3};
        o_illegal = 1'b0;
      end
      OP_I_TYPE: begin
        o_class   = InstI;
        o_alu_src = 1'b1;
        // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate bits
        o_alu_op  = (i_funct3 == 3'b101) ? {i_funct7b5, i_funct3} : {1'b0, i_funct3};
        o_illegal = (i_funct3 == 3'b001) && i_funct7b5;
      end
      OP_S_TYPE: begin
        if (i_funct3 <= 3'd2) begin
          o_class   = InstS;
          o_alu_src = 1'b1;
          o_alu_op  = ALU_ADD;
          o_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I control FSM for R, I-ALU and S instructions.
// Define PERF_CNT_EN to build the retired-instruction counter.
module multi_cycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                iClk,
  input logic                iRst,
  multi_cycle_ctrl_if.master bus
);

  localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

  state_e      r_state;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [7:0]  r_tmo_cnt;
  logic        r_illegal;
  logic        r_fault;

  inst_class_e w_class;
  logic [3:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_dec_illegal;
  logic        w_active;
  logic        w_alu_phase;
  logic        w_unused_inst;

  alu_op_decode u_alu_op_decode (
    .i_opcode   (r_opcode),
    .i_funct3   (r_funct3),
    .i_funct7b5 (r_funct7b5),
    .o_class    (w_class),
    .o_alu_op   (w_alu_op),
    .o_alu_src  (w_alu_src),
    .o_illegal  (w_dec_illegal)
  );

  assign w_unused_inst = ^{bus.iInst_Code[31], bus.iInst_Code[29:15], bus.iInst_Code[11:7]};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= StFetch;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_tmo_cnt  <= '0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        StFetch: begin
          r_opcode   <= bus.iInst_Code[6:0];
          r_funct3   <= bus.iInst_Code[14:12];
          r_funct7b5 <= bus.iInst_Code[30];
          r_state    <= StDecode;
        end
        StDecode: begin
          if (w_class == InstNone) begin
            r_state   <= StTrap;
            r_illegal <= 1'b1;
          end else begin
            r_state <= StExecute;
          end
        end
        StExecute: begin
          // Only a bad I-type shift encoding can still be illegal here
          if (w_dec_illegal) begin
            r_state   <= StTrap;
            r_illegal <= 1'b1;
          end else if (w_class == InstS) begin
            r_state <= StMem;
          end else begin
            r_state <= StWb;
          end
        end
        StWb: r_state <= StFetch;
        StMem: begin
          if (bus.iMem_Ready) begin
            r_state   <= StFetch;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TmoLast) begin
            r_state   <= StTrap;
            r_fault   <= 1'b1;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        StTrap:  r_state <= StTrap;
        default: r_state <= StFetch;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_retired_cnt;
  logic        w_retire;

  assign w_retire = (r_state == StWb) || ((r_state == StMem) && bus.iMem_Ready);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_retired_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign bus.oRetired_Cnt = w_active ? r_retired_cnt : 32'd0;
`else
  assign bus.oRetired_Cnt = 32'd0;
`endif

  // Reset forces every output low even before the reset edge lands
  assign w_active    = !iRst;
  assign w_alu_phase = (r_state == StExecute) || (r_state == StWb) || (r_state == StMem);

  assign bus.oIR_En        = w_active && (r_state == StFetch);
  assign bus.oPC_En        = w_active && ((r_state == StWb) ||
                                          ((r_state == StMem) && bus.iMem_Ready));
  assign bus.oALU_Control  = (w_active && w_alu_phase) ? w_alu_op : 4'b0000;
  assign bus.oALUSrcMuxSel = w_active && w_alu_phase && w_alu_src;
  assign bus.oWrEn         = w_active && (r_state == StWb);
  assign bus.oData_Req     = w_active && (r_state == StMem);
  assign bus.oData_WrEn    = w_active && (r_state == StMem);
  assign bus.oState        = w_active ? r_state : 3'd0;
  assign bus.oIllegal      = w_active && r_illegal;
  assign bus.oFault        = w_active && r_fault;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl (MEM_TIMEOUT = 16).
module tb_multi_cycle_ctrl;

  logic iClk = 1'b0;
  logic iRst;
  int   checks = 0;
  int   errors = 0;

  always #5 iClk = ~iClk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(
    .MEM_TIMEOUT (16)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef PERF_CNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic do_reset();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    #1;
  endtask

  // Run one R/I instruction from FETCH through WB, checking each phase
  task automatic run_alu(input string tag, input logic [31:0] inst,
                         input logic [3:0] op, input logic mux);
    bus.iInst_Code = inst;
    chk({tag, " fetch state"}, 32'(bus.oState), 32'd0);
    chk({tag, " fetch ir_en"}, 32'(bus.oIR_En), 32'd1);
    tick();
    chk({tag, " decode state"}, 32'(bus.oState), 32'd1);
    chk({tag, " decode ir_en"}, 32'(bus.oIR_En), 32'd0);
    tick();
    chk({tag, " exec state"}, 32'(bus.oState), 32'd2);
    chk({tag, " exec alu"}, 32'(bus.oALU_Control), 32'(op));
    chk({tag, " exec mux"}, 32'(bus.oALUSrcMuxSel), 32'(mux));
    chk({tag, " exec wren"}, 32'(bus.oWrEn), 32'd0);
    chk({tag, " exec pc_en"}, 32'(bus.oPC_En), 32'd0);
    tick();
    chk({tag, " wb state"}, 32'(bus.oState), 32'd4);
    chk({tag, " wb alu"}, 32'(bus.oALU_Control), 32'(op));
    chk({tag, " wb mux"}, 32'(bus.oALUSrcMuxSel), 32'(mux));
    chk({tag, " wb wren"}, 32'(bus.oWrEn), 32'd1);
    chk({tag, " wb pc_en"}, 32'(bus.oPC_En), 32'd1);
    chk({tag, " wb data_wren"}, 32'(bus.oData_WrEn), 32'd0);
    tick();
  endtask

  // FETCH -> DECODE -> EXECUTE for a store, leaves the FSM in the first MEM cycle
  task automatic to_mem(input string tag);
    bus.iInst_Code = 32'h0020_A423;
    bus.iMem_Ready = 1'b0;
    tick();
    tick();
    chk({tag, " exec alu"}, 32'(bus.oALU_Control), 32'h0);
    chk({tag, " exec mux"}, 32'(bus.oALUSrcMuxSel), 32'd1);
    chk({tag, " exec wren"}, 32'(bus.oWrEn), 32'd0);
    tick();
  endtask

  initial begin
    iRst           = 1'b1;
    bus.iInst_Code = 32'h0;
    bus.iMem_Ready = 1'b0;

    #1;
    chk("pre-edge reset state", 32'(bus.oState), 32'd0);
    chk("pre-edge reset ir_en", 32'(bus.oIR_En), 32'd0);
    tick();
    chk("reset ir_en", 32'(bus.oIR_En), 32'd0);
    chk("reset illegal", 32'(bus.oIllegal), 32'd0);
    chk("reset fault", 32'(bus.oFault), 32'd0);
    chk("reset retired", bus.oRetired_Cnt, 32'd0);
    iRst = 1'b0;
    #1;

    run_alu("add", 32'h0020_81B3, 4'b0000, 1'b0);
    run_alu("sub", 32'h4020_81B3, 4'b1000, 1'b0);
    run_alu("srai", 32'h4033_5293, 4'b1101, 1'b1);
    run_alu("addi", 32'h0050_8093, 4'b0000, 1'b1);
    chk("retired after 4", bus.oRetired_Cnt, exp_cnt(4));

    // Store accepted on the third MEM cycle
    to_mem("sw");
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin
        bus.iMem_Ready = 1'b1;
        #1;
      end
      chk($sformatf("sw mem%0d state", i), 32'(bus.oState), 32'd3);
      chk($sformatf("sw mem%0d data_wren", i), 32'(bus.oData_WrEn), 32'd1);
      chk($sformatf("sw mem%0d data_req", i), 32'(bus.oData_Req), 32'd1);
      chk($sformatf("sw mem%0d pc_en", i), 32'(bus.oPC_En), 32'(i == 3));
      chk($sformatf("sw mem%0d wren", i), 32'(bus.oWrEn), 32'd0);
      chk($sformatf("sw mem%0d alu", i), 32'(bus.oALU_Control), 32'h0);
      chk($sformatf("sw mem%0d mux", i), 32'(bus.oALUSrcMuxSel), 32'd1);
      tick();
    end
    bus.iMem_Ready = 1'b0;
    #1;
    chk("sw after state", 32'(bus.oState), 32'd0);
    chk("sw after data_wren", 32'(bus.oData_WrEn), 32'd0);
    chk("retired after sw", bus.oRetired_Cnt, exp_cnt(5));

    // Reset during the second MEM cycle aborts the store
    to_mem("sw rst");
    tick();
    chk("sw rst mem2 state", 32'(bus.oState), 32'd3);
    iRst = 1'b1;
    #1;
    chk("rst mid-mem state", 32'(bus.oState), 32'd0);
    chk("rst mid-mem data_wren", 32'(bus.oData_WrEn), 32'd0);
    chk("rst mid-mem pc_en", 32'(bus.oPC_En), 32'd0);
    chk("rst mid-mem retired", bus.oRetired_Cnt, 32'd0);
    tick();
    chk("rst held ir_en", 32'(bus.oIR_En), 32'd0);
    iRst = 1'b0;
    #1;
    chk("after rst state", 32'(bus.oState), 32'd0);
    chk("after rst ir_en", 32'(bus.oIR_En), 32'd1);
    chk("after rst pc_en", 32'(bus.oPC_En), 32'd0);
    chk("after rst retired", bus.oRetired_Cnt, 32'd0);

    for (int n = 0; n < 5; n++) run_alu($sformatf("add%0d", n), 32'h0020_81B3, 4'b0000, 1'b0);
    chk("retired after 5 adds", bus.oRetired_Cnt, exp_cnt(5));

    // Store never accepted: trap after 16 MEM cycles
    to_mem("sw tmo");
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("tmo mem%0d state", i), 32'(bus.oState), 32'd3);
      tick();
    end
    chk("tmo trap state", 32'(bus.oState), 32'd7);
    chk("tmo fault", 32'(bus.oFault), 32'd1);
    chk("tmo illegal", 32'(bus.oIllegal), 32'd0);
    chk("tmo data_wren", 32'(bus.oData_WrEn), 32'd0);
    bus.iMem_Ready = 1'b1;
    #1;
    chk("trap pc_en with ready", 32'(bus.oPC_En), 32'd0);
    tick();
    tick();
    chk("trap absorbing", 32'(bus.oState), 32'd7);
    chk("trap retired held", bus.oRetired_Cnt, exp_cnt(5));
    bus.iMem_Ready = 1'b0;
    do_reset();
    chk("tmo reset fault", 32'(bus.oFault), 32'd0);
    chk("tmo reset state", 32'(bus.oState), 32'd0);

    // Illegal opcode traps from DECODE
    bus.iInst_Code = 32'h0000_007F;
    tick();
    chk("ill decode state", 32'(bus.oState), 32'd1);
    tick();
    chk("ill trap state", 32'(bus.oState), 32'd7);
    chk("ill illegal", 32'(bus.oIllegal), 32'd1);
    chk("ill fault", 32'(bus.oFault), 32'd0);
    tick();
    chk("ill ir_en", 32'(bus.oIR_En), 32'd0);
    do_reset();
    chk("ill reset illegal", 32'(bus.oIllegal), 32'd0);
    chk("ill reset state", 32'(bus.oState), 32'd0);

    // Store with funct3=011 is not supported
    bus.iInst_Code = 32'h0020_B423;
    tick();
    tick();
    chk("sd trap state", 32'(bus.oState), 32'd7);
    chk("sd illegal", 32'(bus.oIllegal), 32'd1);
    do_reset();

    // SLLI with funct7[5]=1 passes DECODE but traps from EXECUTE
    bus.iInst_Code = 32'h4000_1093;
    tick();
    tick();
    chk("bad slli exec state", 32'(bus.oState), 32'd2);
    tick();
    chk("bad slli trap state", 32'(bus.oState), 32'd7);
    chk("bad slli illegal", 32'(bus.oIllegal), 32'd1);
    chk("bad slli wren", 32'(bus.oWrEn), 32'd0);
    do_reset();
    chk("final state", 32'(bus.oState), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
